// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and a saturating count of beats killed by flush.
// Control bits are zeroed whenever the main register holds no beat; the sticky
// field passes through a flush by loading the upstream sticky value.
module pipe_stage_skid #(
    parameter int PAYLOAD_W = 32,
    parameter int CTRL_W    = 8,
    parameter int STICKY_W  = 32,
    parameter int SKID      = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [STICKY_W-1:0]  in_sticky,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [STICKY_W-1:0]  out_sticky,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     kill_count
);

    localparam int SUM_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] KILL_MAX = '1;

    logic                 mainValid_q,   mainValid_d;
    logic [PAYLOAD_W-1:0] mainPayload_q, mainPayload_d;
    logic [CTRL_W-1:0]    mainCtrl_q,    mainCtrl_d;
    logic [STICKY_W-1:0]  mainSticky_q,  mainSticky_d;
    logic                 skidValid_q,   skidValid_d;
    logic [PAYLOAD_W-1:0] skidPayload_q, skidPayload_d;
    logic [CTRL_W-1:0]    skidCtrl_q,    skidCtrl_d;
    logic [STICKY_W-1:0]  skidSticky_q,  skidSticky_d;
    logic [CNT_W-1:0]     killCount_q,   killCount_d;

    logic             inReady;
    logic             accept;
    logic             emit;
    logic [1:0]       occ;
    logic [1:0]       killIncr;
    logic [SUM_W-1:0] killSum;
    logic [CNT_W-1:0] killSat;

    // Handshake terms, occupancy and the saturated kill-count candidate.
    always_comb begin
        if (SKID != 0) begin
            inReady = !skidValid_q;
        end else begin
            inReady = !mainValid_q || out_ready;
        end
        accept   = in_valid && inReady;
        emit     = mainValid_q && out_ready;
        occ      = {1'b0, mainValid_q} + {1'b0, skidValid_q};
        killIncr = occ + {1'b0, accept};
        killSum  = SUM_W'(killCount_q) + SUM_W'(killIncr);
        if (killSum > SUM_W'(KILL_MAX)) begin
            killSat = KILL_MAX;
        end else begin
            killSat = killSum[CNT_W-1:0];
        end
    end

    // Next-state for main register, skid entry and kill counter; flush wins over normal flow.
    always_comb begin
        mainValid_d   = mainValid_q;
        mainPayload_d = mainPayload_q;
        mainCtrl_d    = mainCtrl_q;
        mainSticky_d  = mainSticky_q;
        skidValid_d   = skidValid_q;
        skidPayload_d = skidPayload_q;
        skidCtrl_d    = skidCtrl_q;
        skidSticky_d  = skidSticky_q;
        killCount_d   = killCount_q;

        if (flush) begin
            mainValid_d   = 1'b0;
            mainPayload_d = '0;
            mainCtrl_d    = '0;
            mainSticky_d  = in_sticky;
            skidValid_d   = 1'b0;
            killCount_d   = killSat;
        end else if (skidValid_q) begin
            if (emit) begin
                mainValid_d   = 1'b1;
                mainPayload_d = skidPayload_q;
                mainCtrl_d    = skidCtrl_q;
                mainSticky_d  = skidSticky_q;
                skidValid_d   = 1'b0;
            end
        end else if (accept) begin
            if (!mainValid_q || emit) begin
                mainValid_d   = 1'b1;
                mainPayload_d = in_payload;
                mainCtrl_d    = in_ctrl;
                mainSticky_d  = in_sticky;
            end else begin
                skidValid_d   = 1'b1;
                skidPayload_d = in_payload;
                skidCtrl_d    = in_ctrl;
                skidSticky_d  = in_sticky;
            end
        end else if (emit) begin
            mainValid_d = 1'b0;
            mainCtrl_d  = '0;
        end

        if (SKID == 0) begin
            skidValid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mainValid_q   <= 1'b0;
            mainPayload_q <= '0;
            mainCtrl_q    <= '0;
            mainSticky_q  <= '0;
            skidValid_q   <= 1'b0;
            skidPayload_q <= '0;
            skidCtrl_q    <= '0;
            skidSticky_q  <= '0;
            killCount_q   <= '0;
        end else begin
            mainValid_q   <= mainValid_d;
            mainPayload_q <= mainPayload_d;
            mainCtrl_q    <= mainCtrl_d;
            mainSticky_q  <= mainSticky_d;
            skidValid_q   <= skidValid_d;
            skidPayload_q <= skidPayload_d;
            skidCtrl_q    <= skidCtrl_d;
            skidSticky_q  <= skidSticky_d;
            killCount_q   <= killCount_d;
        end
    end

    assign in_ready    = inReady;
    assign out_valid   = mainValid_q;
    assign out_payload = mainPayload_q;
    assign out_ctrl    = mainCtrl_q;
    assign out_sticky  = mainSticky_q;
    assign occupancy   = occ;
    assign kill_count  = killCount_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: instance A uses the skid buffer with a 2-bit kill
// counter, instance B is the plain single-register variant. Expected beats are
// queued by the stimulus and popped by per-instance monitors on each emit.
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aRst, aInValid, aInReady, aFlush, aOutValid, aOutReady;
    logic [31:0] aInPayload, aInSticky, aOutPayload, aOutSticky;
    logic [7:0]  aInCtrl, aOutCtrl;
    logic [1:0]  aOcc, aKill;

    logic        bRst, bInValid, bInReady, bFlush, bOutValid, bOutReady;
    logic [31:0] bInPayload, bInSticky, bOutPayload, bOutSticky;
    logic [7:0]  bInCtrl, bOutCtrl;
    logic [1:0]  bOcc;
    logic [15:0] bKill;

    int checks = 0;
    int errors = 0;
    int bEmitted = 0;
    logic [39:0] aExpQ[$];
    logic [39:0] bExpQ[$];

    pipe_stage_skid #(.PAYLOAD_W(32), .CTRL_W(8), .STICKY_W(32), .SKID(1), .CNT_W(2)) dutA (
        .clk(clk), .rst(aRst), .in_valid(aInValid), .in_ready(aInReady),
        .in_payload(aInPayload), .in_ctrl(aInCtrl), .in_sticky(aInSticky),
        .flush(aFlush), .out_valid(aOutValid), .out_ready(aOutReady),
        .out_payload(aOutPayload), .out_ctrl(aOutCtrl), .out_sticky(aOutSticky),
        .occupancy(aOcc), .kill_count(aKill)
    );

    pipe_stage_skid #(.PAYLOAD_W(32), .CTRL_W(8), .STICKY_W(32), .SKID(0), .CNT_W(16)) dutB (
        .clk(clk), .rst(bRst), .in_valid(bInValid), .in_ready(bInReady),
        .in_payload(bInPayload), .in_ctrl(bInCtrl), .in_sticky(bInSticky),
        .flush(bFlush), .out_valid(bOutValid), .out_ready(bOutReady),
        .out_payload(bOutPayload), .out_ctrl(bOutCtrl), .out_sticky(bOutSticky),
        .occupancy(bOcc), .kill_count(bKill)
    );

    // Compare one observed value against its expectation.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs to instance A just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] p, input logic [7:0] c,
                                 input logic [31:0] s, input logic fl, input logic ordy);
        @(posedge clk);
        #1;
        aInValid   = v;
        aInPayload = p;
        aInCtrl    = c;
        aInSticky  = s;
        aFlush     = fl;
        aOutReady  = ordy;
    endtask

    // Monitor for instance A: every emit must match the oldest expected beat.
    always @(negedge clk) begin
        if (aRst === 1'b0 && aOutValid === 1'b1 && aOutReady === 1'b1) begin
            if (aExpQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL A unexpected beat actual=%0h expected=none", {aOutPayload, aOutCtrl});
            end else begin
                logic [39:0] exp;
                exp = aExpQ.pop_front();
                checkOutput("A beat", {24'h0, aOutPayload, aOutCtrl}, {24'h0, exp});
            end
        end
    end

    // Monitor for instance B: same ordering check plus an emitted-beat count.
    always @(negedge clk) begin
        if (bRst === 1'b0 && bOutValid === 1'b1 && bOutReady === 1'b1) begin
            bEmitted++;
            if (bExpQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL B unexpected beat actual=%0h expected=none", {bOutPayload, bOutCtrl});
            end else begin
                logic [39:0] exp;
                exp = bExpQ.pop_front();
                checkOutput("B beat", {24'h0, bOutPayload, bOutCtrl}, {24'h0, exp});
            end
        end
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        logic [31:0] p;
        logic [1:0]  expKill[3];
        bit          mValid;
        bit          expReady;
        int          idx;

        aRst = 1'b1; aInValid = 1'b0; aInPayload = '0; aInCtrl = '0; aInSticky = '0;
        aFlush = 1'b0; aOutReady = 1'b0;
        bRst = 1'b1; bInValid = 1'b0; bInPayload = '0; bInCtrl = '0; bInSticky = '0;
        bFlush = 1'b0; bOutReady = 1'b0;

        // Reset for two cycles, then everything idle and ready.
        repeat (2) @(posedge clk);
        #1;
        aRst = 1'b0;
        bRst = 1'b0;
        @(negedge clk);
        checkOutput("T1 A out_valid", aOutValid, 0);
        checkOutput("T1 A out_payload", aOutPayload, 0);
        checkOutput("T1 A out_ctrl", aOutCtrl, 0);
        checkOutput("T1 A out_sticky", aOutSticky, 0);
        checkOutput("T1 A occupancy", aOcc, 0);
        checkOutput("T1 A kill_count", aKill, 0);
        checkOutput("T1 A in_ready", aInReady, 1);
        checkOutput("T1 B out_valid", bOutValid, 0);
        checkOutput("T1 B in_ready", bInReady, 1);
        checkOutput("T1 B kill_count", bKill, 0);

        // Streaming with out_ready=1: one beat per cycle, no bubbles.
        for (int i = 0; i < 8; i++) begin
            p = 32'h10 + 32'(i);
            applyStimulus(1'b1, p, 8'h05, 32'h0, 1'b0, 1'b1);
            aExpQ.push_back({p, 8'h05});
            @(negedge clk);
            checkOutput("T2 in_ready", aInReady, 1);
            if (i > 0) checkOutput("T2 out_valid", aOutValid, 1);
        end
        applyStimulus(1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("T2 last out_valid", aOutValid, 1);
        applyStimulus(1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("T2 drained out_valid", aOutValid, 0);
        checkOutput("T2 drained out_ctrl", aOutCtrl, 0);
        checkOutput("T2 queue empty", 64'(aExpQ.size()), 0);

        // Backpressure: A1 in main, A2 in skid, A3 refused until space frees.
        applyStimulus(1'b1, 32'hA1, 8'h33, 32'h0, 1'b0, 1'b0);
        aExpQ.push_back({32'hA1, 8'h33});
        @(negedge clk);
        checkOutput("T3 ready A1", aInReady, 1);
        applyStimulus(1'b1, 32'hA2, 8'h33, 32'h0, 1'b0, 1'b0);
        aExpQ.push_back({32'hA2, 8'h33});
        @(negedge clk);
        checkOutput("T3 ready A2", aInReady, 1);
        applyStimulus(1'b1, 32'hA3, 8'h33, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("T3 ready full", aInReady, 0);
        checkOutput("T3 occupancy", aOcc, 2);
        checkOutput("T3 out_valid", aOutValid, 1);
        checkOutput("T3 out_payload", aOutPayload, 32'hA1);
        applyStimulus(1'b1, 32'hA3, 8'h33, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("T3 stall payload", aOutPayload, 32'hA1);
        checkOutput("T3 stall ctrl", aOutCtrl, 8'h33);
        applyStimulus(1'b1, 32'hA3, 8'h33, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("T3 release ready", aInReady, 0);
        applyStimulus(1'b1, 32'hA3, 8'h33, 32'h0, 1'b0, 1'b1);
        aExpQ.push_back({32'hA3, 8'h33});
        @(negedge clk);
        checkOutput("T3 ready after skid drain", aInReady, 1);
        checkOutput("T3 payload A2", aOutPayload, 32'hA2);
        applyStimulus(1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("T3 payload A3", aOutPayload, 32'hA3);
        applyStimulus(1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("T3 occupancy empty", aOcc, 0);
        checkOutput("T3 queue empty", 64'(aExpQ.size()), 0);

        // Flush with both entries full and a refused incoming beat.
        applyStimulus(1'b1, 32'hB1, 8'h44, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB2, 8'h44, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("T4 occupancy before", aOcc, 2);
        applyStimulus(1'b1, 32'hB3, 8'h44, 32'hDEAD, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("T4 ready in flush", aInReady, 0);
        applyStimulus(1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("T4 out_valid", aOutValid, 0);
        checkOutput("T4 out_ctrl", aOutCtrl, 0);
        checkOutput("T4 out_payload", aOutPayload, 0);
        checkOutput("T4 out_sticky", aOutSticky, 32'hDEAD);
        checkOutput("T4 occupancy", aOcc, 0);
        checkOutput("T4 kill_count", aKill, 2);
        checkOutput("T4 in_ready", aInReady, 1);

        // Kill counter saturation on a freshly reset 2-bit counter.
        @(posedge clk);
        #1 aRst = 1'b1;
        @(posedge clk);
        #1 aRst = 1'b0;
        @(negedge clk);
        checkOutput("T5 kill after reset", aKill, 0);
        expKill[0] = 2'd2;
        expKill[1] = 2'd3;
        expKill[2] = 2'd3;
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1'b1, 32'hC0, 8'h11, 32'h0, 1'b0, 1'b0);
            applyStimulus(1'b1, 32'hC1, 8'h11, 32'h0, 1'b0, 1'b0);
            applyStimulus(1'b0, 32'h0, 8'h0, 32'h0, 1'b1, 1'b0);
            applyStimulus(1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("T5 kill_count", aKill, 64'(expKill[r]));
        end

        // Single-register variant with toggling out_ready and continuous input.
        mValid = 1'b0;
        idx = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            bOutReady  = (k % 2 == 0);
            bInValid   = (idx < 6);
            bInPayload = 32'h60 + 32'(idx);
            bInCtrl    = 8'(idx + 1);
            expReady   = !mValid || bOutReady;
            @(negedge clk);
            checkOutput("T6 in_ready", bInReady, 64'(expReady));
            checkOutput("T6 out_valid", bOutValid, 64'(mValid));
            if (bInValid && expReady) begin
                bExpQ.push_back({bInPayload, bInCtrl});
                idx++;
                mValid = 1'b1;
            end else if (mValid && bOutReady) begin
                mValid = 1'b0;
            end
        end
        checkOutput("T6 beats emitted", 64'(bEmitted), 6);
        checkOutput("T6 queue empty", 64'(bExpQ.size()), 0);

        // Reset asserted in the middle of a stream.
        @(posedge clk);
        #1;
        bOutReady = 1'b0; bInValid = 1'b1; bInPayload = 32'h70; bInCtrl = 8'h77; bInSticky = 32'h99;
        @(posedge clk);
        #1;
        bInPayload = 32'h71;
        bRst = 1'b1;
        @(posedge clk);
        #1;
        bRst = 1'b0;
        bInValid = 1'b0;
        @(negedge clk);
        checkOutput("T6 rst out_valid", bOutValid, 0);
        checkOutput("T6 rst out_payload", bOutPayload, 0);
        checkOutput("T6 rst out_ctrl", bOutCtrl, 0);
        checkOutput("T6 rst out_sticky", bOutSticky, 0);
        checkOutput("T6 rst occupancy", bOcc, 0);
        checkOutput("T6 rst in_ready", bInReady, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
